// File: rtl/fetch_unit.sv
// Instruction fetch FSM: issues one memory read per fetch and holds the word
// until decode takes it; flush, timeout and misalignment handled here.
module fetch_unit #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        en,
  input  logic [31:0] pc_val,
  input  logic        flush,
  input  logic        fault_clr,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        pc_stall,
  output logic        pc_load,
  output logic        fault
);

  localparam logic [7:0] TMO = 8'(TIMEOUT);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_DRAIN,
    S_HOLD,
    S_FAULT
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  cnt_inc;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_IDLE;
      addr_q  <= 32'h0;
      instr_q <= NOP;
      valid_q <= 1'b0;
      cnt_q   <= 8'h0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  // wait counter saturates so a huge TIMEOUT can never wrap back to 0
  assign cnt_inc = (cnt_q == 8'hff) ? cnt_q : cnt_q + 8'd1;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (en) begin
          addr_d = pc_val;
          cnt_d  = 8'h0;
          if (pc_val[1:0] != 2'b00) state_d = S_FAULT;
          else                      state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          if (flush) begin
            state_d = S_IDLE;
          end else begin
            instr_d = mem_rdata;
            valid_d = 1'b1;
            state_d = S_HOLD;
          end
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc >= TMO) state_d = S_FAULT;
          else if (flush)     state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (mem_ack) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc >= TMO) state_d = S_FAULT;
        end
      end
      S_HOLD: begin
        if (flush || instr_ready) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      S_FAULT: begin
        if (fault_clr) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_req     = (state_q == S_REQ) || (state_q == S_DRAIN);
  assign mem_addr    = addr_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign fault       = (state_q == S_FAULT);
  assign pc_stall    = (state_q != S_IDLE);
  assign pc_load     = valid_q & instr_ready & ~flush;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then random traffic against a
// transaction-level reference model.
module tb_fetch_unit;

  localparam int TMO = 15;

  logic        clk = 1'b0;
  logic        clr;
  logic        en;
  logic [31:0] pc_val;
  logic        flush;
  logic        fault_clr;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        pc_stall;
  logic        pc_load;
  logic        fault;

  int n_cmp = 0;
  int n_bad = 0;

  bit          m_busy;
  bit          m_drop;
  bit          m_have;
  bit          m_fault;
  int          m_waits;
  logic [31:0] m_addr;
  logic [31:0] m_instr;

  fetch_unit #(.TIMEOUT(TMO)) dut (
    .clk        (clk),
    .clr        (clr),
    .en         (en),
    .pc_val     (pc_val),
    .flush      (flush),
    .fault_clr  (fault_clr),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .instr      (instr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .pc_stall   (pc_stall),
    .pc_load    (pc_load),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy  = 0;
    m_drop  = 0;
    m_have  = 0;
    m_fault = 0;
    m_waits = 0;
    m_addr  = 32'h0;
    m_instr = 32'h0000_0013;
  endtask

  // One clock of the fetch contract, in terms of the outstanding transaction
  task automatic model_step();
    if (m_fault) begin
      if (fault_clr) m_fault = 0;
    end else if (m_busy) begin
      if (mem_ack) begin
        m_busy = 0;
        if (!m_drop && !flush) begin
          m_have  = 1;
          m_instr = mem_rdata;
        end
      end else begin
        m_waits++;
        if (m_waits >= TMO) begin
          m_busy  = 0;
          m_fault = 1;
        end else if (flush) begin
          m_drop = 1;
        end
      end
    end else if (m_have) begin
      if (flush || instr_ready) m_have = 0;
    end else if (en) begin
      m_addr = pc_val;
      if (pc_val[1:0] != 2'b00) begin
        m_fault = 1;
      end else begin
        m_busy  = 1;
        m_drop  = 0;
        m_waits = 0;
      end
    end
  endtask

  task automatic check_all();
    chk("mem_req", mem_req, m_busy);
    chk("mem_addr", mem_addr, m_addr);
    chk("instr", instr, m_instr);
    chk("instr_valid", instr_valid, m_have);
    chk("pc_stall", pc_stall, m_busy | m_have | m_fault);
    chk("fault", fault, m_fault);
    chk("pc_load", pc_load, m_have & instr_ready & ~flush);
  endtask

  task automatic quiet();
    en          = 0;
    flush       = 0;
    fault_clr   = 0;
    mem_ack     = 0;
    instr_ready = 0;
  endtask

  task automatic cyc();
    #2;
    chk("pc_load_pre", pc_load, m_have & instr_ready & ~flush);
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_mem_req"}, mem_req, 1'b0);
    chk({tag, "_mem_addr"}, mem_addr, 32'h0);
    chk({tag, "_instr"}, instr, 32'h0000_0013);
    chk({tag, "_valid"}, instr_valid, 1'b0);
    chk({tag, "_fault"}, fault, 1'b0);
    chk({tag, "_stall"}, pc_stall, 1'b0);
  endtask

  int loads;
  bit slow;

  initial begin
    clr       = 1;
    pc_val    = 32'h0;
    mem_rdata = 32'h0;
    quiet();
    model_reset();
    #1;
    chk_reset_outs("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    clr = 0;
    check_all();

    // basic fetch, ack three cycles after request
    pc_val = 32'h100;
    en = 1;
    cyc();
    en = 0;
    chk("req_addr", mem_addr, 32'h100);
    cyc();
    cyc();
    mem_ack = 1;
    mem_rdata = 32'h0050_0093;
    cyc();
    mem_ack = 0;
    chk("fetch_instr", instr, 32'h0050_0093);
    chk("fetch_valid", instr_valid, 1'b1);
    loads = 0;
    cyc();
    instr_ready = 1;
    #2;
    if (pc_load) loads++;
    cyc();
    if (pc_load) loads++;
    instr_ready = 0;
    chk("single_load", loads, 1);

    // misaligned pc
    pc_val = 32'h102;
    en = 1;
    cyc();
    chk("mis_fault", fault, 1'b1);
    chk("mis_noreq", mem_req, 1'b0);
    flush = 1;
    cyc();
    cyc();
    en = 0;
    flush = 0;
    fault_clr = 1;
    cyc();
    fault_clr = 0;
    chk("mis_clr", fault, 1'b0);

    // timeout with no ack
    pc_val = 32'h200;
    en = 1;
    cyc();
    en = 0;
    for (int i = 0; i < TMO - 1; i++) cyc();
    chk("tmo_early", fault, 1'b0);
    cyc();
    chk("tmo_fault", fault, 1'b1);
    chk("tmo_stall", pc_stall, 1'b1);
    cyc();
    fault_clr = 1;
    cyc();
    fault_clr = 0;

    // flush during request, ack arrives later and is dropped
    pc_val = 32'h300;
    en = 1;
    cyc();
    en = 0;
    flush = 1;
    cyc();
    flush = 0;
    cyc();
    chk("drain_req", mem_req, 1'b1);
    chk("drain_addr", mem_addr, 32'h300);
    mem_ack = 1;
    mem_rdata = 32'hdead_beef;
    cyc();
    mem_ack = 0;
    chk("drain_instr", instr, 32'h0050_0093);
    chk("drain_valid", instr_valid, 1'b0);

    // held instruction, then flush with ready in the same cycle
    pc_val = 32'h400;
    en = 1;
    cyc();
    en = 0;
    mem_ack = 1;
    mem_rdata = 32'h1234_5678;
    cyc();
    mem_ack = 0;
    for (int i = 0; i < 5; i++) cyc();
    chk("hold_instr", instr, 32'h1234_5678);
    chk("hold_stall", pc_stall, 1'b1);
    flush = 1;
    instr_ready = 1;
    #2;
    chk("flush_noload", pc_load, 1'b0);
    cyc();
    flush = 0;
    instr_ready = 0;
    chk("flush_idle", pc_stall, 1'b0);

    // asynchronous clear mid-request, late ack ignored
    pc_val = 32'h500;
    en = 1;
    cyc();
    en = 0;
    cyc();
    #2;
    clr = 1;
    #1;
    chk_reset_outs("aclr");
    model_reset();
    @(posedge clk);
    #1;
    clr = 0;
    mem_ack = 1;
    mem_rdata = 32'hffff_ffff;
    cyc();
    mem_ack = 0;
    chk("late_ack", instr_valid, 1'b0);

    // random traffic
    slow = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) slow = ~slow;
      en          = $urandom_range(0, 1) == 1;
      pc_val      = $urandom();
      if ($urandom_range(0, 9) != 0) pc_val[1:0] = 2'b00;
      flush       = $urandom_range(0, 9) == 0;
      fault_clr   = $urandom_range(0, 4) == 0;
      instr_ready = $urandom_range(0, 1) == 1;
      mem_ack     = slow ? ($urandom_range(0, 24) == 0)
                         : ($urandom_range(0, 1) == 1);
      mem_rdata   = $urandom();
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter TIMEOUT, default 15, maximum cycles waiting for mem_ack before FAULT (range 1..255).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 clr  input  1  reset, asynchronous, active-high.
REQ-004 en  input  1  permits a new fetch from IDLE.
REQ-005 pc_val  input  32  current program counter from PC block.
REQ-006 flush  input  1  branch/jump taken; discard in-flight or held instruction.
REQ-007 fault_clr  input  1  clears FAULT state.
REQ-008 mem_req  output  1  instruction-memory read request.
REQ-009 mem_addr  output  32  read address, registered.
REQ-010 mem_ack  input  1  memory completion strobe; mem_rdata valid in same cycle.
REQ-011 mem_rdata  input  32  instruction word from memory.
REQ-012 instr  output  32  fetched instruction, registered.
REQ-013 instr_valid  output  1  instr holds a valid instruction for decode.
REQ-014 instr_ready  input  1  decode accepts instr this cycle.
REQ-015 pc_stall  output  1  drives PC Disable; high when state is REQ, DRAIN, HOLD or FAULT.
REQ-016 pc_load  output  1  one-cycle pulse advancing PC; equals instr_valid & instr_ready & ~flush.
REQ-017 fault  output  1  high exactly when state is FAULT; misaligned PC or timeout.

Function
REQ-018 FSM states SHALL be IDLE, REQ, DRAIN, HOLD, FAULT; mem_req high only in REQ and DRAIN.
REQ-019 IDLE: en=1 and pc_val[1:0]=0 -> mem_addr<=pc_val, wait counter<=0, go REQ.
REQ-020 IDLE: en=1 and pc_val[1:0]!=0 -> mem_addr<=pc_val, go FAULT; no memory request issued.
REQ-021 REQ: mem_ack=1, flush=0 -> instr<=mem_rdata, instr_valid<=1, go HOLD.
REQ-022 REQ: mem_ack=0 -> counter increments; counter reaching TIMEOUT with no ack -> go FAULT.
REQ-023 REQ: flush=1 with mem_ack=1 -> data dropped, instr unchanged, go IDLE (flush wins).
REQ-024 REQ: flush=1 with mem_ack=0 -> go DRAIN, counter continues.
REQ-025 DRAIN: mem_ack=1 -> data dropped, go IDLE; same TIMEOUT rule as REQ -> FAULT.
REQ-026 HOLD: instr and instr_valid stable until instr_ready=1; then instr_valid<=0, go IDLE.
REQ-027 HOLD: flush=1 -> instr_valid<=0, go IDLE, pc_load stays 0 even if instr_ready=1.
REQ-028 FAULT: sticky; en and flush ignored; fault_clr=1 -> go IDLE next cycle.
REQ-029 Latency: en sampled at edge N -> mem_req high after edge N; ack at edge N+k -> instr_valid high after N+k; minimum fetch-to-valid 2 cycles.
REQ-030 Counter 8 bits, saturating; never wraps.
REQ-031 mem_addr SHALL not change while mem_req is high.

Reset
REQ-032 clr=1 SHALL immediately force state IDLE, mem_req=0, mem_addr=0, instr=32'h0000_0013 (NOP), instr_valid=0, fault=0, counter=0.
REQ-033 clr asserted mid-transaction abandons it; a late mem_ack after clr release is ignored in IDLE.

Verification
REQ-034 pc_val=0x100, en=1, ack 3 cycles later with rdata=0x00500093 -> mem_addr=0x100, instr=0x00500093, instr_valid=1; instr_ready=1 -> single pc_load pulse.
REQ-035 pc_val=0x102, en=1 -> fault=1, mem_req never asserted; fault_clr=1 -> IDLE, fault=0.
REQ-036 TIMEOUT=15, no ack -> fault=1 on the 15th wait cycle, pc_stall stays 1.
REQ-037 flush during REQ, ack 2 cycles later -> DRAIN, data dropped, instr remains previous value, instr_valid=0.
REQ-038 HOLD with instr_ready=0 for 5 cycles -> instr stable, pc_stall=1; flush+instr_ready same cycle -> pc_load=0, IDLE.
REQ-039 clr pulse during REQ -> all outputs at reset values asynchronously; instr=0x00000013.
